mem_port_arbiter: RTL and testbench

Shares the single-port unified instruction/data memory between the instruction-fetch stage and the load/store stage of the MIPS core. Arbitrates one access at a time and sequences it through issue, latency wait and response. Reads return registered data to the winning requester; writes complete after issue. By default data accesses have priority, and an optional starvation guard protects fetch.

---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and load/store.
// Latency: mem_en one cycle after acceptance; read data returned MEM_LAT+2 cycles after acceptance.
// Backpressure: requesters hold requests until ready; one access in flight; optional macro ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          lat_q, lat_d;
  logic                owner_q, owner_d;        // 1 = load/store port owns the access
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                idle;
  logic                fetch_wins;
  logic                grant_i;
  logic                grant_d;

  // ready is gated by rst_n so nothing is offered while reset is held
  assign idle = (state_q == IDLE) && rst_n;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;

  assign fetch_wins = if_req && (!d_req || (starve_q >= 4'(STARVE_MAX)));

  // count data grants that bypassed a waiting fetch; any other arbitration clears it
  always_comb begin
    starve_d = starve_q;
    if (grant_d && if_req) begin
      starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
    end else if (grant_i || grant_d) begin
      starve_d = '0;
    end
  end

  // starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign fetch_wins = if_req && !d_req;
`endif

  assign grant_i  = idle && fetch_wins;
  assign grant_d  = idle && d_req && !fetch_wins;
  assign if_ready = grant_i;
  assign d_ready  = grant_d;

  // next-state and datapath next values; strobes default low, data registers hold
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    owner_d     = owner_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_i || grant_d) begin
          mem_en_d    = 1'b1;
          mem_we_d    = grant_d && d_we;
          mem_addr_d  = grant_d ? d_addr : if_addr;
          mem_wdata_d = grant_d ? d_wdata : '0;
          owner_d     = grant_d;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // mem_we_q still holds the captured direction during ISSUE
        if (mem_we_q) begin
          state_d = IDLE;
        end else begin
          lat_d   = 4'(MEM_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          state_d = RESP;
          if (owner_q) begin
            d_rdata_d  = mem_rdata;
            d_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = mem_rdata;
            if_rvalid_d = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      owner_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a scoreboard for grants, memory strobes and read responses.
// Instance u_dut runs with MEM_LAT=1, u_dut3 with MEM_LAT=3 (fetch only).
// Expectations are queued when a request is issued; the negedge monitor pops and compares.
module tb_mem_port_arbiter;

  typedef struct { int inst; int port; int cyc; } grant_t;                         // port 0 = fetch, 1 = data
  typedef struct { int inst; logic we; logic [31:0] addr; logic [31:0] wdata; int cyc; } memx_t;
  typedef struct { int inst; int port; logic [31:0] data; int cyc; } resp_t;

  grant_t      grant_q[$];
  memx_t       mem_q[$];
  resp_t       resp_q[$];
  logic [31:0] rd_at [int];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance 0 (MEM_LAT=1)
  logic        if_req, if_ready, if_rvalid, d_req, d_we, d_ready, d_rvalid;
  logic        mem_en, mem_we, busy;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  // instance 1 (MEM_LAT=3)
  logic        f_if_req, f_if_ready, f_if_rvalid, f_d_req, f_d_we, f_d_ready, f_d_rvalid;
  logic        f_mem_en, f_mem_we, f_busy;
  logic [31:0] f_if_addr, f_if_rdata, f_d_addr, f_d_wdata, f_d_rdata, f_mem_addr, f_mem_wdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(f_if_req), .if_addr(f_if_addr), .if_ready(f_if_ready), .if_rvalid(f_if_rvalid), .if_rdata(f_if_rdata),
    .d_req(f_d_req), .d_we(f_d_we), .d_addr(f_d_addr), .d_wdata(f_d_wdata), .d_ready(f_d_ready),
    .d_rvalid(f_d_rvalid), .d_rdata(f_d_rdata),
    .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_rdata(mem_rdata), .busy(f_busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event with no expectation queued (cycle %0d)", nm, cyc);
  endtask

  // memory read data: scheduled word in its sampling cycle, junk otherwise
  initial begin
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rdata = rd_at.exists(cyc) ? rd_at[cyc] : (32'hBAD0_0000 ^ 32'(cyc));
    end
  end

  task automatic mon(input int inst, input logic ifr, input logic dr, input logic me, input logic mwe,
                     input logic [31:0] ma, input logic [31:0] mwd, input logic ivld,
                     input logic [31:0] ird, input logic dvld, input logic [31:0] drd);
    grant_t g;
    memx_t  m;
    resp_t  r;
    if (ifr || dr) begin
      chk("ready_exclusive", 64'(ifr & dr), 64'd0);
      if (grant_q.size() == 0) unexpected("grant");
      else begin
        g = grant_q.pop_front();
        chk("grant_inst", 64'(inst), 64'(g.inst));
        chk("grant_port", 64'(dr), 64'(g.port));
        chk("grant_cycle", 64'(cyc), 64'(g.cyc));
      end
    end
    if (me) begin
      if (mem_q.size() == 0) unexpected("mem_en");
      else begin
        m = mem_q.pop_front();
        chk("mem_inst", 64'(inst), 64'(m.inst));
        chk("mem_addr", 64'(ma), 64'(m.addr));
        chk("mem_we", 64'(mwe), 64'(m.we));
        if (m.we) chk("mem_wdata", 64'(mwd), 64'(m.wdata));
        chk("mem_cycle", 64'(cyc), 64'(m.cyc));
      end
    end
    if (ivld) begin
      if (resp_q.size() == 0) unexpected("if_rvalid");
      else begin
        r = resp_q.pop_front();
        chk("if_resp_inst", 64'(inst), 64'(r.inst));
        chk("if_resp_port", 64'd0, 64'(r.port));
        chk("if_rdata", 64'(ird), 64'(r.data));
        chk("if_resp_cycle", 64'(cyc), 64'(r.cyc));
      end
    end
    if (dvld) begin
      if (resp_q.size() == 0) unexpected("d_rvalid");
      else begin
        r = resp_q.pop_front();
        chk("d_resp_inst", 64'(inst), 64'(r.inst));
        chk("d_resp_port", 64'd1, 64'(r.port));
        chk("d_rdata", 64'(drd), 64'(r.data));
        chk("d_resp_cycle", 64'(cyc), 64'(r.cyc));
      end
    end
  endtask

  // monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, if_ready, d_ready, mem_en, mem_we, mem_addr, mem_wdata, if_rvalid, if_rdata, d_rvalid, d_rdata);
      mon(1, f_if_ready, f_d_ready, f_mem_en, f_mem_we, f_mem_addr, f_mem_wdata,
          f_if_rvalid, f_if_rdata, f_d_rvalid, f_d_rdata);
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) next();
  endtask

  task automatic chk_zero();
    chk("rst_ctl0",   64'({if_ready, d_ready, if_rvalid, d_rvalid, mem_en, mem_we, busy}), 64'd0);
    chk("rst_mem0",   {mem_addr, mem_wdata}, 64'd0);
    chk("rst_rdata0", {if_rdata, d_rdata}, 64'd0);
    chk("rst_ctl1",   64'({f_if_ready, f_d_ready, f_if_rvalid, f_d_rvalid, f_mem_en, f_mem_we, f_busy}), 64'd0);
    chk("rst_rdata1", {f_if_rdata, f_d_rdata}, 64'd0);
  endtask

  // issue one request at the start of the current cycle (DUT must be idle) and queue its expectations
  task automatic issue(input int inst, input int port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdat, output int nxt);
    int c;
    int lat;
    c   = cyc;
    lat = (inst == 0) ? 1 : 3;
    grant_q.push_back('{inst, port, c});
    mem_q.push_back('{inst, we, addr, wdata, c + 1});
    if (!we) begin
      resp_q.push_back('{inst, port, rdat, c + 2 + lat});
      rd_at[c + 1 + lat] = rdat;
    end
    if (inst == 1) begin
      f_if_req = 1'b1; f_if_addr = addr;
    end else if (port == 1) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    next();
    f_if_req = 1'b0; if_req = 1'b0; d_req = 1'b0;
    nxt = we ? c + 2 : c + 3 + lat;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nxt;
    int c;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    f_if_req = 0; f_if_addr = 0; f_d_req = 0; f_d_we = 0; f_d_addr = 0; f_d_wdata = 0;
    rst_n = 1'b0;

    // reset with random inputs: every output stays 0
    for (int i = 0; i < 3; i++) begin
      next();
      if_req = 1'($urandom_range(0, 1)); d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
      if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
      f_if_req = 1'($urandom_range(0, 1)); f_if_addr = $urandom;
      f_d_req = 1'($urandom_range(0, 1)); f_d_we = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_zero();
    end
    next();
    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    f_if_req = 0; f_if_addr = 0; f_d_req = 0; f_d_we = 0; f_d_addr = 0; f_d_wdata = 0;
    rst_n = 1'b1;

    // first fetch right out of reset
    issue(0, 0, 1'b0, 32'h100, 32'h0, 32'h1111_2222, nxt);
    wait_until(nxt);

    // single load, MEM_LAT=1: rvalid at T+3, idle at T+4
    c = cyc;
    issue(0, 1, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, nxt);
    wait_until(c + 3);
    @(negedge clk);
    chk("busy_resp", 64'(busy), 64'd1);
    wait_until(c + 4);
    @(negedge clk);
    chk("busy_after_read", 64'(busy), 64'd0);
    next();

    // store, then a fetch accepted two cycles after the store
    c = cyc;
    issue(0, 1, 1'b1, 32'h80, 32'h1234, 32'h0, nxt);
    chk("write_turnaround", 64'(nxt), 64'(c + 2));
    wait_until(nxt);
    issue(0, 0, 1'b0, 32'h104, 32'h0, 32'h0F0F_1234, nxt);
    wait_until(nxt);
    @(negedge clk);
    chk("d_rdata_hold", 64'(d_rdata), 64'h0000_0000_DEAD_BEEF);
    chk("if_rdata_hold", 64'(if_rdata), 64'h0000_0000_0F0F_1234);
    next();

    // contention: both held, stores on the data side
    c = cyc;
`ifdef ARB_STARVE_GUARD_EN
    for (int k = 0; k < 4; k++) begin
      grant_q.push_back('{0, 1, c + 2 * k});
      mem_q.push_back('{0, 1'b1, 32'h400, 32'h55, c + 2 * k + 1});
    end
    grant_q.push_back('{0, 0, c + 8});
    mem_q.push_back('{0, 1'b0, 32'h300, 32'h0, c + 9});
    rd_at[c + 10] = 32'h600D_F00D;
    resp_q.push_back('{0, 0, 32'h600D_F00D, c + 11});
    grant_q.push_back('{0, 1, c + 12});
    mem_q.push_back('{0, 1'b1, 32'h400, 32'h55, c + 13});
    d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = 32'h55; if_req = 1; if_addr = 32'h300;
    wait_until(c + 13);
    d_req = 0; if_req = 0;
    wait_until(c + 14);
`else
    for (int k = 0; k < 5; k++) begin
      grant_q.push_back('{0, 1, c + 2 * k});
      mem_q.push_back('{0, 1'b1, 32'h400, 32'h55, c + 2 * k + 1});
    end
    grant_q.push_back('{0, 0, c + 10});
    mem_q.push_back('{0, 1'b0, 32'h300, 32'h0, c + 11});
    rd_at[c + 12] = 32'h600D_F00D;
    resp_q.push_back('{0, 0, 32'h600D_F00D, c + 13});
    d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = 32'h55; if_req = 1; if_addr = 32'h300;
    wait_until(c + 9);
    d_req = 0;
    wait_until(c + 11);
    if_req = 0;
    wait_until(c + 14);
`endif

    // latency sweep on the MEM_LAT=3 instance: if_rvalid at T+5 carrying the T+4 word
    issue(1, 0, 1'b0, 32'h200, 32'h0, 32'hCAFE_F00D, nxt);
    wait_until(nxt);

    // reset during WAIT aborts the load with no rvalid
    c = cyc;
    grant_q.push_back('{0, 1, c});
    mem_q.push_back('{0, 1'b0, 32'h44, 32'h0, c + 1});
    rd_at[c + 2] = 32'h7777_7777;
    d_req = 1; d_we = 0; d_addr = 32'h44;
    next();
    d_req = 0;
    next();
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", 64'({mem_en, busy, if_rvalid, d_rvalid, if_ready, d_ready}), 64'd0);
    chk("midrst_rdata", 64'(d_rdata), 64'd0);
    next();
    next();
    rst_n = 1'b1;
    repeat (8) next();
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);

    chk("grant_q_empty", 64'(grant_q.size()), 64'd0);
    chk("mem_q_empty", 64'(mem_q.size()), 64'd0);
    chk("resp_q_empty", 64'(resp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
